// File: rtl/parity_frame_checker.sv
`default_nettype none
// ============================================================================
//  Module      : parity_frame_checker
//  Description : Receive-side checker for a framed stream of 2-bit symbols
//                (FRAME_SYMS data symbols followed by one parity symbol).
//                Deserialises the data, recomputes the running XOR parity
//                and flags parity and framing errors in the parity symbol.
//  Ports       : clk      - clock, all flops on posedge
//                rst      - asynchronous reset, active-high
//                x_valid  - x_in/x_sof valid this cycle
//                x_sof    - start of frame, x_in is data symbol 0
//                x_in     - 2-bit symbol (data or parity)
//                y_valid  - 1-cycle pulse, frame complete, y_* valid
//                y_data   - deserialised frame, symbol k at [2k+1:2k]
//                y_perr   - parity mismatch of the last completed frame
//                y_ferr   - parity symbol had equal bits (framing error)
//                y_abort  - 1-cycle pulse, partial frame dropped by x_sof
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_checker #(
  parameter int FRAME_SYMS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    x_valid,
  input  logic                    x_sof,
  input  logic [1:0]              x_in,
  output logic                    y_valid,
  output logic [2*FRAME_SYMS-1:0] y_data,
  output logic                    y_perr,
  output logic                    y_ferr,
  output logic                    y_abort
);

  localparam int CNT_W = $clog2(FRAME_SYMS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_SYMS - 1);
  localparam logic [CNT_W-1:0] ONE_IDX  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        idx;
  logic                    acc;
  // Frame is assembled here so that y_data only changes on completion.
  logic [2*FRAME_SYMS-1:0] shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      acc     <= 1'b0;
      shadow  <= '0;
      y_valid <= 1'b0;
      y_data  <= '0;
      y_perr  <= 1'b0;
      y_ferr  <= 1'b0;
      y_abort <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      y_abort <= 1'b0;
      if (x_valid) begin
        if (x_sof) begin
          // A start-of-frame always restarts as symbol 0; outside IDLE the
          // partial frame in flight is dropped and reported.
          if (state != IDLE) begin
            y_abort <= 1'b1;
          end
          shadow[1:0] <= x_in;
          acc         <= ^x_in;
          idx         <= ONE_IDX;
          state       <= DATA;
        end else begin
          case (state)
            IDLE: begin
              // Stray symbols outside a frame are ignored.
            end
            DATA: begin
              for (int k = 0; k < FRAME_SYMS; k++) begin
                if (idx == CNT_W'(k)) begin
                  shadow[2*k +: 2] <= x_in;
                end
              end
              acc <= acc ^ (^x_in);
              idx <= idx + ONE_IDX;
              if (idx == LAST_IDX) begin
                state <= PAR;
              end
            end
            PAR: begin
              y_valid <= 1'b1;
              y_data  <= shadow;
              y_perr  <= (x_in[0] != acc);
              y_ferr  <= (x_in[1] == x_in[0]);
              state   <= IDLE;
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_frame_checker
//  Description : Self-checking bench for parity_frame_checker (FRAME_SYMS=4).
//                A frame-level model built on a symbol queue predicts every
//                output each cycle; directed tests add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_frame_checker;

  localparam int FRAME_SYMS = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    x_valid = 1'b0;
  logic                    x_sof = 1'b0;
  logic [1:0]              x_in = 2'b00;
  logic                    y_valid;
  logic [2*FRAME_SYMS-1:0] y_data;
  logic                    y_perr;
  logic                    y_ferr;
  logic                    y_abort;

  int tests = 0;
  int fails = 0;

  parity_frame_checker #(.FRAME_SYMS(FRAME_SYMS)) dut (
    .clk     (clk),
    .rst     (rst),
    .x_valid (x_valid),
    .x_sof   (x_sof),
    .x_in    (x_in),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_perr  (y_perr),
    .y_ferr  (y_ferr),
    .y_abort (y_abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  logic                    exp_valid = 1'b0;
  logic                    exp_abort = 1'b0;
  logic [2*FRAME_SYMS-1:0] exp_data  = '0;
  logic                    exp_perr  = 1'b0;
  logic                    exp_ferr  = 1'b0;
  logic [1:0]              frame_q[$];
  bit                      in_frame = 1'b0;

  initial begin
    logic                    p;
    logic [2*FRAME_SYMS-1:0] d;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        frame_q.delete();
        in_frame  = 1'b0;
        exp_valid = 1'b0;
        exp_abort = 1'b0;
        exp_data  = '0;
        exp_perr  = 1'b0;
        exp_ferr  = 1'b0;
      end else begin
        exp_valid = 1'b0;
        exp_abort = 1'b0;
        if (x_valid) begin
          if (x_sof) begin
            if (in_frame) exp_abort = 1'b1;
            frame_q.delete();
            frame_q.push_back(x_in);
            in_frame = 1'b1;
          end else if (in_frame) begin
            if (frame_q.size() < FRAME_SYMS) begin
              frame_q.push_back(x_in);
            end else begin
              p = 1'b0;
              d = '0;
              foreach (frame_q[k]) begin
                p = p ^ frame_q[k][0] ^ frame_q[k][1];
                d[2*k +: 2] = frame_q[k];
              end
              exp_valid = 1'b1;
              exp_data  = d;
              exp_perr  = (x_in[0] != p);
              exp_ferr  = (x_in[1] == x_in[0]);
              frame_q.delete();
              in_frame = 1'b0;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int cyc     = 0;
  int last_vc = 0;
  int prev_vc = 0;

  always @(negedge clk) begin
    cyc++;
    check("y_valid", 32'(y_valid), 32'(exp_valid));
    check("y_abort", 32'(y_abort), 32'(exp_abort));
    check("y_data",  32'(y_data),  32'(exp_data));
    check("y_perr",  32'(y_perr),  32'(exp_perr));
    check("y_ferr",  32'(y_ferr),  32'(exp_ferr));
    if (y_valid) begin
      prev_vc = last_vc;
      last_vc = cyc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic sof, input logic [1:0] s);
    @(negedge clk);
    x_valid = 1'b1;
    x_sof   = sof;
    x_in    = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      x_valid = 1'b0;
      x_sof   = 1'b0;
    end
  endtask

  // T1 data 01,10,11,00 with optional gaps after each symbol
  task automatic t1_frame(input logic [1:0] par, input int g0, input int g1,
                          input int g2, input int g3);
    send(1'b1, 2'b01); idle(g0);
    send(1'b0, 2'b10); idle(g1);
    send(1'b0, 2'b11); idle(g2);
    send(1'b0, 2'b00); idle(g3);
    send(1'b0, par);
  endtask

  // Called right after the parity symbol was driven.
  task automatic expect_done(input string name, input logic [7:0] d,
                             input logic pe, input logic fe);
    idle(1);
    check({name, "_valid"}, 32'(y_valid), 32'd1);
    check({name, "_data"},  32'(y_data),  32'(d));
    check({name, "_perr"},  32'(y_perr),  32'(pe));
    check({name, "_ferr"},  32'(y_ferr),  32'(fe));
  endtask

  initial begin
    // reset state
    idle(2);
    check("rst_valid", 32'(y_valid), 32'd0);
    check("rst_data",  32'(y_data),  32'd0);
    check("rst_abort", 32'(y_abort), 32'd0);
    rst = 1'b0;
    idle(2);

    // T1 good frame
    t1_frame(2'b10, 0, 0, 0, 0);
    expect_done("t1", 8'h39, 1'b0, 1'b0);
    idle(1);
    check("t1_pulse", 32'(y_valid), 32'd0);

    // T2 parity bit wrong
    t1_frame(2'b01, 0, 0, 0, 0);
    expect_done("t2", 8'h39, 1'b1, 1'b0);

    // T3 framing errors
    t1_frame(2'b11, 0, 0, 0, 0);
    expect_done("t3a", 8'h39, 1'b1, 1'b1);
    t1_frame(2'b00, 0, 0, 0, 0);
    expect_done("t3b", 8'h39, 1'b0, 1'b1);

    // T4 gaps, then stray symbols while idle
    t1_frame(2'b10, 0, 1, 2, 3);
    expect_done("t4", 8'h39, 1'b0, 1'b0);
    send(1'b0, 2'b11);
    send(1'b0, 2'b01);
    send(1'b0, 2'b10);
    idle(2);
    check("t4_stray_valid", 32'(y_valid), 32'd0);
    check("t4_stray_data",  32'(y_data),  32'h39);

    // T5 abort by a new start-of-frame
    send(1'b1, 2'b01);
    send(1'b0, 2'b10);
    send(1'b1, 2'b11);
    send(1'b0, 2'b11);
    check("t5_abort", 32'(y_abort), 32'd1);
    check("t5_hold",  32'(y_data),  32'h39);
    send(1'b0, 2'b11);
    check("t5_abort_end", 32'(y_abort), 32'd0);
    send(1'b0, 2'b11);
    send(1'b0, 2'b10);
    expect_done("t5", 8'hFF, 1'b0, 1'b0);

    // T6 asynchronous mid-frame reset
    send(1'b1, 2'b01);
    send(1'b0, 2'b10);
    idle(1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_data",  32'(y_data),  32'd0);
    check("t6_async_valid", 32'(y_valid), 32'd0);
    check("t6_async_abort", 32'(y_abort), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(1);
    send(1'b0, 2'b00);  // no frame open after reset: ignored
    idle(1);
    check("t6_noframe", 32'(y_valid), 32'd0);
    t1_frame(2'b10, 0, 0, 0, 0);
    expect_done("t6", 8'h39, 1'b0, 1'b0);

    // back-to-back frames with no bubble
    t1_frame(2'b10, 0, 0, 0, 0);
    t1_frame(2'b10, 0, 0, 0, 0);
    expect_done("b2b", 8'h39, 1'b0, 1'b0);
    idle(2);
    check("b2b_spacing", 32'(last_vc - prev_vc), 32'd5);

    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
